// File: rtl/prbs_gen_multi.sv
// PRBS-7/15/23/31 source, W_OUT bits per beat (earliest bit in MSB); optional error injection via PRBS_GEN_ERR_INJ_EN.
// Latency: one cycle from an accepted advance to valid.
// Backpressure: valid & ~ready holds the beat and the LFSR; load flushes the beat regardless of ready.
module prbs_gen_multi #(
  parameter int W_OUT     = 4,
  parameter int RST_MODE  = 2,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 load,
  input  logic [1:0]           mode_in,
  input  logic [30:0]          seed_in,
  input  logic                 err_inj,
  output logic [W_OUT-1:0]     bits_out,
  output logic                 valid,
  input  logic                 ready,
  output logic [1:0]           mode_out,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [1:0] RST_MODE_B = 2'(RST_MODE);

  function automatic logic [30:0] len_mask(input logic [1:0] m);
    case (m)
      2'd0:    return 31'h0000_007F;
      2'd1:    return 31'h0000_7FFF;
      2'd2:    return 31'h007F_FFFF;
      default: return 31'h7FFF_FFFF;
    endcase
  endfunction

  // Bits above the active length stay zero because every step rebuilds the word from N-1 bits.
  function automatic logic [30:0] lfsr_step(input logic [30:0] s, input logic [1:0] m);
    case (m)
      2'd0:    return {24'b0, s[5:0],  s[6]  ^ s[5]};
      2'd1:    return {16'b0, s[13:0], s[14] ^ s[13]};
      2'd2:    return {8'b0,  s[21:0], s[22] ^ s[17]};
      default: return {s[29:0], s[30] ^ s[27]};
    endcase
  endfunction

  function automatic logic lfsr_msb(input logic [30:0] s, input logic [1:0] m);
    case (m)
      2'd0:    return s[6];
      2'd1:    return s[14];
      2'd2:    return s[22];
      default: return s[30];
    endcase
  endfunction

  logic [30:0]      state_q, state_d, state_adv, seed_m;
  logic [1:0]       mode_q, mode_d;
  logic [W_OUT-1:0] bits_q, bits_d, beat_raw;
  logic             valid_q, valid_d;
  logic             adv;
  logic             inj_msb;

  assign adv = en & (~valid_q | ready) & ~load;

  always_comb begin : beat_gen
    logic [30:0] st;
    st       = state_q;
    beat_raw = '0;
    for (int i = 0; i < W_OUT; i++) begin
      beat_raw[W_OUT-1-i] = lfsr_msb(st, mode_q);
      st = lfsr_step(st, mode_q);
    end
    state_adv = st;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    bits_d  = bits_q;
    valid_d = valid_q;
    seed_m  = seed_in & len_mask(mode_in);
    if (load) begin
      mode_d  = mode_in;
      state_d = (seed_m == '0) ? len_mask(mode_in) : seed_m;
      valid_d = 1'b0;
    end else if (adv) begin
      state_d            = state_adv;
      bits_d             = beat_raw;
      bits_d[W_OUT-1]    = beat_raw[W_OUT-1] ^ inj_msb;
      valid_d            = 1'b1;
    end else if (valid_q & ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= len_mask(RST_MODE_B);
      mode_q  <= RST_MODE_B;
      bits_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      bits_q  <= bits_d;
      valid_q <= valid_d;
    end
  end

`ifdef PRBS_GEN_ERR_INJ_EN
  logic                 pend_q, pend_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign inj_msb = adv & pend_q;

  // A pulse arriving on the consuming cycle re-arms the flag for the following beat.
  always_comb begin
    pend_d    = pend_q | err_inj;
    err_cnt_d = err_cnt_q;
    if (load) begin
      pend_d = 1'b0;
    end else if (inj_msb) begin
      pend_d = err_inj;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      pend_q    <= pend_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_inj;
  assign unused_err_inj = err_inj;
  assign inj_msb        = 1'b0;
  assign err_cnt        = '0;
`endif

  assign bits_out = bits_q;
  assign valid    = valid_q;
  assign mode_out = mode_q;

endmodule

// File: doc/prbs_gen_multi.md
Name: prbs_gen_multi

Overview:
- Parametrised PRBS source; successor to the fixed PRBS-23 bit source.
- Runtime-selectable polynomial (PRBS-7/15/23/31) and parameterised parallel output width.
- Valid/ready output handshake and runtime seed load.
- Feeds the QAM mapper and BER test paths.
- Parallel output beat carries W_OUT consecutive serial bits, earliest bit in the MSB.

Parameters:
- W_OUT, 4, bits per output beat (1..32).
- RST_MODE, 2, polynomial selected at reset (0=PRBS7, 1=PRBS15, 2=PRBS23, 3=PRBS31).
- ERR_CNT_W, 16, width of injected-error counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- en  in  1  generation enable.
- load  in  1  single-cycle seed/mode load strobe.
- mode_in  in  2  polynomial select, sampled only on load.
- seed_in  in  31  seed, sampled only on load; only the low N bits are used.
- err_inj  in  1  error-injection request pulse (optional feature).
- bits_out  out  W_OUT  output beat; bits_out[W_OUT-1] is the earliest bit.
- valid  out  1  bits_out holds a beat.
- ready  in  1  downstream accept.
- mode_out  out  2  currently active mode.
- err_cnt  out  ERR_CNT_W  count of injected errors (optional feature).

Behaviour:
- Polynomials:
  - PRBS7: x^7+x^6+1.
  - PRBS15: x^15+x^14+1.
  - PRBS23: x^23+x^18+1.
  - PRBS31: x^31+x^28+1.
- State: 31-bit register; the active length N uses state[N-1:0]. Unused bits are held 0.
- One step: fb = s[N-1] ^ s[TAP-1]; s = {s[N-2:0], fb} (confined to N bits).
- Serial output bit is s[N-1] before each step.
- Beat generation: W_OUT steps unrolled combinationally per beat. bits_out[W_OUT-1-i] = MSB of intermediate state i.
- Reset:
  - state = all-ones in the low N bits for RST_MODE; mode_r = RST_MODE.
  - bits_out = 0, valid = 0, err_cnt = 0, pending-inject = 0.
- Advance condition: adv = en & (~valid | ready) & ~load.
  - On adv: state advances W_OUT steps, bits_out is registered, valid = 1 next cycle.
  - Latency: 1 cycle from adv to valid.
- Drain: if ready & valid & ~adv, valid drops to 0 next cycle.
- Stall: while valid & ~ready, bits_out, valid and state hold stable. The LFSR never advances on a stalled beat, so no bits are lost.
- Load:
  - mode_r <= mode_in; state <= seed_in masked to N(mode_in) bits.
  - A masked seed of zero is replaced with all-ones (lock-up guard).
  - valid <= 0, which flushes any pending beat even if ready is 0.
  - Load has priority over adv in the same cycle; no beat is produced that cycle.
  - First beat after load uses the new seed: the MSB of bits_out equals seed bit N-1.
- Mode change is only via load. mode_in is ignored otherwise. mode_out = mode_r.
- en low with valid=1 and ready=1: beat consumed, valid -> 0, state holds.
- Reset asserted mid-stream: all outputs return to reset values asynchronously. Generation restarts from the RST_MODE all-ones seed.
- The sequence period is 2^N - 1 bits. With W_OUT coprime to the period, the beat sequence period is also 2^N - 1 beats.

Optional Feature:
- Macro: PRBS_GEN_ERR_INJ_EN.
- Defined:
  - An err_inj pulse sets a pending flag; multiple pulses before consumption collapse into one.
  - The next generated beat (next adv) has bits_out[W_OUT-1] inverted. The LFSR state is unaffected, so the stream stays in sync.
  - Pending flag clears and err_cnt increments, saturating at all-ones.
  - Load clears the pending flag but not err_cnt.
- Not defined: err_inj is ignored, err_cnt is tied to 0, and no injection logic is synthesised.

Test Plan:
- Reset, W_OUT=4, RST_MODE=0, en=1, ready=1 -> beats 4'hF, 4'hE, 4'h0, then valid continuous; 127 beats later the 4'hF, 4'hE, 4'h0 pattern repeats.
- RST_MODE=2, W_OUT=4, en=1, ready=1 -> first 23 serial bits all 1, then bits match the reference x^23+x^18+1 model for 10^5 bits.
- Stall: ready=0 for 5 cycles after valid -> bits_out and valid stable; on resume the next beat is contiguous (no skipped bits vs model).
- load with mode_in=1, seed_in=0, simultaneous en=1 and valid=1, ready=0 -> next cycle valid=0, mode_out=1, state=15'h7FFF; first beat = 4'hF.
- load seed_in=31'h4000_0000, mode_in=3 -> first beat MSB = 1, remaining bits match the PRBS31 model.
- With PRBS_GEN_ERR_INJ_EN: two err_inj pulses during a stall -> exactly one beat has its MSB flipped vs model, err_cnt=1, and subsequent beats match the model.
